lane_regfile: RTL and testbench

Per-lane register file for the SIMD core, one instance per lane alongside that lane's ALU. It supplies the ALU's `rm`/`rn` operands in the request phase. In the update phase it writes back one of three sources: the ALU result, load data returned by the memory path, or a decoded immediate. It also exposes three read-only registers (block id, block dim, lane/thread id) so kernels can compute addresses.

---
 rtl/lane_regfile_pkg.sv | 32 +++
 rtl/lane_regfile_if.sv | 34 +++
 rtl/lane_regfile.sv | 109 ++++++++++
 tb/tb_lane_regfile.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lane_regfile_pkg.sv
// Shared SIMD core encodings: phase codes, writeback sources, read-only register
// indices and ALU opcodes.
package lane_regfile_pkg;

    localparam logic [2:0] SIMD_IDLE    = 3'd0;
    localparam logic [2:0] SIMD_FETCH   = 3'd1;
    localparam logic [2:0] SIMD_DECODE  = 3'd2;
    localparam logic [2:0] SIMD_REQUEST = 3'd3;
    localparam logic [2:0] SIMD_WAIT    = 3'd4;
    localparam logic [2:0] SIMD_EXECUTE = 3'd5;
    localparam logic [2:0] SIMD_UPDATE  = 3'd6;
    localparam logic [2:0] SIMD_DONE    = 3'd7;

    localparam logic [1:0] REG_SRC_ALU  = 2'b00;
    localparam logic [1:0] REG_SRC_MEM  = 2'b01;
    localparam logic [1:0] REG_SRC_IMM  = 2'b10;
    localparam logic [1:0] REG_SRC_NONE = 2'b11;

    localparam int unsigned REG_BLOCK_ID  = 13;
    localparam int unsigned REG_BLOCK_DIM = 14;
    localparam int unsigned REG_THREAD_ID = 15;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_MUL = 4'd2;
    localparam logic [3:0] ALU_DIV = 4'd3;
    localparam logic [3:0] ALU_AND = 4'd4;
    localparam logic [3:0] ALU_OR  = 4'd5;
    localparam logic [3:0] ALU_XOR = 4'd6;
    localparam logic [3:0] ALU_CMP = 4'd7;

endpackage

// File: rtl/lane_regfile_if.sv
// Core-to-register-file bus for one SIMD lane; the core is master, the register
// file is slave.
interface lane_regfile_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  enable;
    logic [2:0]            simd_state;
    logic [7:0]            block_id;
    logic [3:0]            rm_addr;
    logic [3:0]            rn_addr;
    logic [3:0]            rd_addr;
    logic                  reg_write_en;
    logic [1:0]            reg_src;
    logic [7:0]            imm;
    logic [DATA_WIDTH-1:0] alu_out;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_valid;
    logic [DATA_WIDTH-1:0] rm;
    logic [DATA_WIDTH-1:0] rn;
    logic                  wb_done;
    logic                  load_miss;

    modport master (
        output enable, simd_state, block_id, rm_addr, rn_addr, rd_addr, reg_write_en,
               reg_src, imm, alu_out, mem_data, mem_valid,
        input  rm, rn, wb_done, load_miss
    );

    modport slave (
        input  enable, simd_state, block_id, rm_addr, rn_addr, rd_addr, reg_write_en,
               reg_src, imm, alu_out, mem_data, mem_valid,
        output rm, rn, wb_done, load_miss
    );
endinterface

// File: rtl/lane_regfile.sv
// Per-lane register file: registered rm/rn operand reads in REQUEST, writeback of
// ALU/MEM/IMM data in UPDATE, with R13-R15 as read-only lane constants.
module lane_regfile
    import lane_regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 64,
    parameter int unsigned NUM_REGS          = 16,
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned LANE_ID           = 0
) (
    input logic           clk,
    input logic           rst,
    lane_regfile_if.slave bus
);
    localparam int unsigned NUM_GPR = REG_BLOCK_ID;

    logic [DATA_WIDTH-1:0] gpr_q [NUM_GPR];
    logic [DATA_WIDTH-1:0] rm_q, rn_q, mem_buf_q;
    logic                  mem_buf_valid_q, wb_done_q, load_miss_q;

    logic [DATA_WIDTH-1:0] view [NUM_REGS];
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rd_req, wr_req, commit, miss, mem_consume;

    // Architectural view: writable GPRs followed by the read-only lane constants.
    always_comb begin
        for (int i = 0; i < NUM_GPR; i++) begin
            view[i] = gpr_q[i];
        end
        view[REG_BLOCK_ID]  = DATA_WIDTH'(bus.block_id);
        view[REG_BLOCK_DIM] = DATA_WIDTH'(THREADS_PER_BLOCK);
        view[REG_THREAD_ID] = DATA_WIDTH'(LANE_ID);
    end

    always_comb begin
        rd_req      = bus.enable && (bus.simd_state == SIMD_REQUEST);
        wr_req      = bus.enable && (bus.simd_state == SIMD_UPDATE) && bus.reg_write_en &&
                      (bus.rd_addr < 4'(REG_BLOCK_ID));
        wdata       = bus.alu_out;
        commit      = 1'b0;
        miss        = 1'b0;
        mem_consume = 1'b0;
        if (wr_req) begin
            case (bus.reg_src)
                REG_SRC_ALU: commit = 1'b1;
                REG_SRC_IMM: begin
                    wdata  = DATA_WIDTH'(bus.imm);
                    commit = 1'b1;
                end
                REG_SRC_MEM: begin
                    // Same-cycle strobe bypasses the buffer; buffered data is the fallback.
                    if (bus.mem_valid) begin
                        wdata       = bus.mem_data;
                        commit      = 1'b1;
                        mem_consume = 1'b1;
                    end else if (mem_buf_valid_q) begin
                        wdata       = mem_buf_q;
                        commit      = 1'b1;
                        mem_consume = 1'b1;
                    end else begin
                        miss = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= '0;
            end
            rm_q            <= '0;
            rn_q            <= '0;
            mem_buf_q       <= '0;
            mem_buf_valid_q <= 1'b0;
            wb_done_q       <= 1'b0;
            load_miss_q     <= 1'b0;
        end else begin
            wb_done_q <= commit;
            if (rd_req) begin
                rm_q <= view[bus.rm_addr];
                rn_q <= view[bus.rn_addr];
            end
            if (commit) begin
                gpr_q[bus.rd_addr] <= wdata;
            end
            if (miss) begin
                load_miss_q <= 1'b1;
            end
            if (bus.enable && bus.mem_valid) begin
                mem_buf_q <= bus.mem_data;
            end
            // A consuming MEM write wins over a capture in the same cycle.
            if (mem_consume) begin
                mem_buf_valid_q <= 1'b0;
            end else if (bus.enable && bus.mem_valid) begin
                mem_buf_valid_q <= 1'b1;
            end
        end
    end

    assign bus.rm        = rm_q;
    assign bus.rn        = rn_q;
    assign bus.wb_done   = wb_done_q;
    assign bus.load_miss = load_miss_q;

endmodule

// File: tb/tb_lane_regfile.sv
// Self-checking bench for lane_regfile: directed scenarios with literal expectations
// plus randomized instructions checked every cycle against a behavioural model.
module tb_lane_regfile;
    import lane_regfile_pkg::*;

    localparam int unsigned DW  = 64;
    localparam int unsigned TPB = 4;
    localparam int unsigned LID = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic last_wb;

    always #5 clk = ~clk;

    lane_regfile_if #(.DATA_WIDTH(DW)) bus ();

    lane_regfile #(
        .DATA_WIDTH(DW),
        .NUM_REGS(16),
        .THREADS_PER_BLOCK(TPB),
        .LANE_ID(LID)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Behavioural model: architectural registers, operand latches, load buffer, flags.
    logic [DW-1:0] m_reg [16];
    logic [DW-1:0] m_rm, m_rn, m_buf;
    logic          m_bufv, m_wb, m_miss;

    function automatic logic [DW-1:0] m_value(input logic [3:0] a);
        if (a <= 4'd12) return m_reg[a];
        if (a == 4'd13) return {{(DW-8){1'b0}}, bus.block_id};
        if (a == 4'd14) return DW'(TPB);
        return DW'(LID);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
        m_rm = '0; m_rn = '0; m_buf = '0;
        m_bufv = 1'b0; m_wb = 1'b0; m_miss = 1'b0;
    endtask

    task automatic model_step();
        logic [DW-1:0] nbuf;
        logic          nbv, wrote;
        nbuf = m_buf; nbv = m_bufv; wrote = 1'b0;
        if (bus.enable) begin
            if (bus.mem_valid) begin
                nbuf = bus.mem_data;
                nbv  = 1'b1;
            end
            if (bus.simd_state == SIMD_REQUEST) begin
                m_rm = m_value(bus.rm_addr);
                m_rn = m_value(bus.rn_addr);
            end
            if (bus.simd_state == SIMD_UPDATE && bus.reg_write_en && bus.rd_addr <= 4'd12) begin
                if (bus.reg_src == REG_SRC_ALU) begin
                    m_reg[bus.rd_addr] = bus.alu_out; wrote = 1'b1;
                end else if (bus.reg_src == REG_SRC_IMM) begin
                    m_reg[bus.rd_addr] = {{(DW-8){1'b0}}, bus.imm}; wrote = 1'b1;
                end else if (bus.reg_src == REG_SRC_MEM) begin
                    if (bus.mem_valid) begin
                        m_reg[bus.rd_addr] = bus.mem_data; wrote = 1'b1; nbv = 1'b0;
                    end else if (m_bufv) begin
                        m_reg[bus.rd_addr] = m_buf; wrote = 1'b1; nbv = 1'b0;
                    end else begin
                        m_miss = 1'b1;
                    end
                end
            end
        end
        m_buf = nbuf; m_bufv = nbv; m_wb = wrote;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rm", bus.rm, m_rm);
            chk("rn", bus.rn, m_rn);
            chk("wb_done", DW'(bus.wb_done), DW'(m_wb));
            chk("load_miss", DW'(bus.load_miss), DW'(m_miss));
        end
    end

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    task automatic idle();
        bus.enable = 1'b1; bus.simd_state = SIMD_IDLE; bus.reg_write_en = 1'b0;
        bus.reg_src = REG_SRC_NONE; bus.mem_valid = 1'b0;
        tick();
    endtask

    task automatic instr(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd,
                         input logic we, input logic [1:0] src, input logic [7:0] im,
                         input logic [DW-1:0] alu, input int mem_phase,
                         input logic [DW-1:0] md, input logic en, input logic rnd);
        for (int st = 1; st <= 7; st++) begin
            bus.simd_state   = 3'(st);
            bus.rm_addr      = ra; bus.rn_addr = rb; bus.rd_addr = rd;
            bus.reg_write_en = we; bus.reg_src = src; bus.imm = im; bus.alu_out = alu;
            bus.enable       = rnd ? ($urandom_range(0, 7) != 0) : en;
            bus.mem_valid    = rnd ? ($urandom_range(0, 4) == 0) : (st == mem_phase);
            bus.mem_data     = rnd ? {$urandom, $urandom} : md;
            tick();
            if (st == 6) last_wb = bus.wb_done;
        end
        idle();
    endtask

    initial begin
        bus.enable = 1'b1; bus.simd_state = SIMD_IDLE; bus.block_id = 8'h2A;
        bus.rm_addr = '0; bus.rn_addr = '0; bus.rd_addr = '0; bus.reg_write_en = 1'b0;
        bus.reg_src = REG_SRC_NONE; bus.imm = '0; bus.alu_out = '0;
        bus.mem_data = '0; bus.mem_valid = 1'b0;
        model_reset();
        #1 rst = 1'b0;
        #1;
        chk("reset_rm", bus.rm, '0);
        chk("reset_wb_done", DW'(bus.wb_done), '0);
        chk("reset_load_miss", DW'(bus.load_miss), '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle();

        // ALU writeback then read back, with block id on rn
        instr(4'd0, 4'd0, 4'd5, 1'b1, REG_SRC_ALU, 8'h0, 64'h1234, -1, '0, 1'b1, 1'b0);
        chk("alu_wb_done", DW'(last_wb), 64'd1);
        instr(4'd5, 4'd13, 4'd0, 1'b0, REG_SRC_NONE, 8'h0, '0, -1, '0, 1'b1, 1'b0);
        chk("alu_readback", bus.rm, 64'h1234);
        chk("block_id_read", bus.rn, 64'h2A);

        // Immediate and read-only registers
        instr(4'd0, 4'd0, 4'd2, 1'b1, REG_SRC_IMM, 8'hFF, 64'hBAD, -1, '0, 1'b1, 1'b0);
        instr(4'd2, 4'd15, 4'd0, 1'b0, REG_SRC_NONE, 8'h0, '0, -1, '0, 1'b1, 1'b0);
        chk("imm_readback", bus.rm, 64'hFF);
        chk("lane_id_read", bus.rn, 64'd3);
        instr(4'd0, 4'd0, 4'd14, 1'b1, REG_SRC_ALU, 8'h0, 64'h999, -1, '0, 1'b1, 1'b0);
        chk("r14_write_no_wb", DW'(last_wb), '0);
        instr(4'd14, 4'd13, 4'd0, 1'b0, REG_SRC_NONE, 8'h0, '0, -1, '0, 1'b1, 1'b0);
        chk("r14_unchanged", bus.rm, 64'd4);

        // Load captured in WAIT, consumed in UPDATE; second MEM write misses
        instr(4'd0, 4'd0, 4'd7, 1'b1, REG_SRC_MEM, 8'h0, '0, 4, 64'hDEAD, 1'b1, 1'b0);
        chk("load_wb_done", DW'(last_wb), 64'd1);
        instr(4'd0, 4'd0, 4'd7, 1'b1, REG_SRC_MEM, 8'h0, '0, -1, '0, 1'b1, 1'b0);
        chk("miss_no_wb", DW'(last_wb), '0);
        chk("load_miss_set", DW'(bus.load_miss), 64'd1);
        instr(4'd7, 4'd0, 4'd0, 1'b0, REG_SRC_NONE, 8'h0, '0, -1, '0, 1'b1, 1'b0);
        chk("load_readback", bus.rm, 64'hDEAD);

        // Bypass: strobe in the UPDATE cycle itself
        instr(4'd0, 4'd0, 4'd7, 1'b1, REG_SRC_MEM, 8'h0, '0, 6, 64'hBEEF, 1'b1, 1'b0);
        instr(4'd7, 4'd2, 4'd0, 1'b0, REG_SRC_NONE, 8'h0, '0, -1, '0, 1'b1, 1'b0);
        chk("bypass_readback", bus.rm, 64'hBEEF);

        // Enable gating: reads, writes and load capture all suppressed
        instr(4'd0, 4'd0, 4'd4, 1'b1, REG_SRC_ALU, 8'h0, 64'h77, 4, 64'h5555, 1'b0, 1'b0);
        chk("gated_no_wb", DW'(last_wb), '0);
        chk("gated_rm_hold", bus.rm, 64'hBEEF);
        chk("gated_rn_hold", bus.rn, 64'hFF);
        instr(4'd4, 4'd7, 4'd0, 1'b0, REG_SRC_NONE, 8'h0, '0, -1, '0, 1'b1, 1'b0);
        chk("gated_r4_zero", bus.rm, '0);
        chk("gated_r7_kept", bus.rn, 64'hBEEF);

        // Asynchronous reset mid-UPDATE discards the write
        bus.rd_addr = 4'd3; bus.reg_write_en = 1'b1; bus.reg_src = REG_SRC_ALU;
        bus.alu_out = 64'hAAAA; bus.mem_valid = 1'b0; bus.enable = 1'b1;
        for (int st = 1; st <= 5; st++) begin
            bus.simd_state = 3'(st);
            tick();
        end
        bus.simd_state = SIMD_UPDATE;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_rn", bus.rn, '0);
        chk("async_rst_miss", DW'(bus.load_miss), '0);
        chk("async_rst_wb", DW'(bus.wb_done), '0);
        model_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        idle();
        instr(4'd3, 4'd7, 4'd0, 1'b0, REG_SRC_NONE, 8'h0, '0, -1, '0, 1'b1, 1'b0);
        chk("rst_r3_zero", bus.rm, '0);
        chk("rst_r7_zero", bus.rn, '0);

        // Randomized instructions against the model
        for (int n = 0; n < 400; n++) begin
            bus.block_id = 8'($urandom);
            instr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 8'($urandom), {$urandom, $urandom},
                  -1, '0, 1'b1, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
